// File: rtl/scratchpad_mem.sv
// Single-port word-addressed data scratchpad answering LSU memory requests.
// Optional per-word even parity is compiled in with `define SPM_PARITY_EN.
//
// state | meaning
// INIT  | clearing the array one word per cycle after reset
// IDLE  | waiting for mem_req
// BUSY  | request latched, counting down the access latency
// RESP  | mem_ready pulse cycle
module scratchpad_mem #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter int              LATENCY     = 1,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            reset_n,
`ifdef SPM_PARITY_EN
  input  logic            inject_parity_err,
`endif
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            mem_ready,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_error,
  output logic            init_done
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [AW-1:0]   init_ptr;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            lat_we;
  logic            lat_err;
  logic [XLEN-1:0] lat_wdata;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [XLEN-1:0] off;
  logic            req_err;
  logic [AW-1:0]   req_idx;
  logic            fire;
  logic [XLEN-1:0] rd_word;
  logic            rd_bad;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_data;

  assign off     = mem_addr - BASE_ADDR;
  assign req_err = (mem_addr[1:0] != 2'b00) || (mem_addr[XLEN-1 -: 4] == 4'hF) ||
                   ({1'b0, off} >= SPAN);
  assign req_idx = off[AW+1:2];
  assign fire    = (state == BUSY) && (cnt == '0);
  assign rd_word = mem[idx];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = lat_wdata;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_ptr;
      wr_data = '0;
    end else if (fire && lat_we && !lat_err) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

`ifdef SPM_PARITY_EN
  logic par [DEPTH_WORDS];
  logic lat_inj;
  logic wr_flip;

  // Injection only ever corrupts a requested write, never the INIT clear.
  assign wr_flip = (state != INIT) && lat_inj;
  assign rd_bad  = (par[idx] != ^rd_word);

  always_ff @(posedge clk) begin
    if (wr_en) par[wr_idx] <= (^wr_data) ^ wr_flip;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       lat_inj <= 1'b0;
    else if (state == IDLE && mem_req)  lat_inj <= inject_parity_err;
  end
`else
  assign rd_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      init_ptr  <= '0;
      idx       <= '0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mem_error <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + AW'(1);
          if (init_ptr == AW'(DEPTH_WORDS - 1)) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: begin
          if (mem_req) begin
            lat_we    <= mem_we;
            lat_wdata <= mem_wdata;
            lat_err   <= req_err;
            idx       <= req_idx;
            cnt       <= CW'(LATENCY - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            mem_ready <= 1'b1;
            state     <= RESP;
            if (lat_err || lat_we) begin
              mem_error <= lat_err;
              mem_rdata <= '0;
            end else if (rd_bad) begin
              mem_error <= 1'b1;
              mem_rdata <= '0;
            end else begin
              mem_error <= 1'b0;
              mem_rdata <= rd_word;
            end
          end
        end
        RESP: begin
          // mem_req seen on this edge belongs to the transaction just answered.
          mem_ready <= 1'b0;
          mem_error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_mem.sv
// Bench for scratchpad_mem: one instance at LATENCY=1, one at LATENCY=3.
// Parity checks are compiled only when SPM_PARITY_EN is defined.
module tb_scratchpad_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        idone [2];
`ifdef SPM_PARITY_EN
  logic        inj;
`endif

  always #5 clk = ~clk;

  scratchpad_mem #(.LATENCY(1)) u0 (
    .clk(clk), .reset_n(reset_n),
`ifdef SPM_PARITY_EN
    .inject_parity_err(inj),
`endif
    .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_error(err[0]), .init_done(idone[0])
  );

  scratchpad_mem #(.LATENCY(3)) u1 (
    .clk(clk), .reset_n(reset_n),
`ifdef SPM_PARITY_EN
    .inject_parity_err(1'b0),
`endif
    .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_error(err[1]), .init_done(idone[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    bit          e;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[16];
  logic [31:0] held[2];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive a request and wait for its response; b2b means the previous
  // response pulse was seen on the last negedge and req is held through RESP.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] dat,
                     input logic [31:0] exp_rd, input bit exp_e, input bit b2b);
    exp_t e;
    int   n;
    int   want;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dat;
    sbq.push_back('{rdata: exp_rd, err: exp_e});
    want = ((d == 1) ? 3 : 1) + (b2b ? 2 : 1);
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (b2b && n == 1) begin
        check($sformatf("pulse_drop d%0d", d), 32'(ready[d]), 32'd0);
        check($sformatf("err_clear d%0d", d), 32'(err[d]), 32'd0);
        check($sformatf("rdata_hold d%0d", d), rdata[d], held[d]);
      end
    end while (!ready[d] && n < 40);
    e = sbq.pop_front();
    if (!ready[d]) begin
      total++; bad++;
      $display("FAIL timeout d%0d addr %h: got no ready want ready", d, a);
    end else begin
      check($sformatf("latency d%0d %h", d, a), 32'(n), 32'(want));
      check($sformatf("rdata d%0d %h", d, a), rdata[d], e.rdata);
      check($sformatf("error d%0d %h", d, a), 32'(err[d]), 32'(e.err));
      held[d] = e.rdata;
    end
  endtask

  task automatic finish_txn(input int d);
    req[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    check($sformatf("end_ready d%0d", d), 32'(ready[d]), 32'd0);
    check($sformatf("end_err d%0d", d), 32'(err[d]), 32'd0);
    check($sformatf("end_hold d%0d", d), rdata[d], held[d]);
  endtask

  task automatic wait_init(output int n, output int early);
    n = 0; early = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
      if (ready[0] || ready[1]) early++;
    end while (!(idone[0] && idone[1]) && n < 3000);
  endtask

  initial begin
    int n;
    int early;

    tbl[0]  = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0042, 32'h1234_5678, 32'h0,         1'b1};
    tbl[3]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
    tbl[5]  = '{1'b0, 32'hF000_0000, 32'h0,         32'h0,         1'b1};
    tbl[6]  = '{1'b1, 32'h0000_0FFC, 32'h1122_3344, 32'h0,         1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h1122_3344, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0,         1'b0};
    tbl[9]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_1001, 32'h0,         32'h0,         1'b1};
    tbl[12] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0};
    tbl[13] = '{1'b1, 32'h0000_0044, 32'h0000_0001, 32'h0,         1'b0};
    tbl[14] = '{1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[15] = '{1'b0, 32'h0000_0044, 32'h0,         32'h0000_0001, 1'b0};

    held[0] = '0; held[1] = '0;
`ifdef SPM_PARITY_EN
    inj = 1'b0;
`endif
    reset_n = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; wdata[0] = '0;
    req[1] = 1'b0; we[1] = 1'b0; addr[1] = '0;    wdata[1] = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", 32'(ready[0]), 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_error", 32'(err[0]), 32'd0);
    check("rst_init_done", 32'(idone[0]), 32'd0);

    // Request held through INIT is accepted on the first IDLE edge.
    reset_n = 1'b1;
    wait_init(n, early);
    check("init_edges", 32'(n), 32'd1024);
    check("init_done_lat3", 32'(idone[1]), 32'd1);
    check("no_ready_in_init", 32'(early), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    finish_txn(0);

    for (int i = 0; i < 16; i++)
      txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].e, i > 0);
    finish_txn(0);

    txn(1, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    finish_txn(1);

`ifdef SPM_PARITY_EN
    inj = 1'b1;
    txn(0, 1'b1, 32'h20, 32'h1, 32'h0, 1'b0, 1'b0);
    finish_txn(0);
    inj = 1'b0;
    txn(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0);
    txn(0, 1'b1, 32'h20, 32'h1, 32'h0, 1'b0, 1'b1);
    txn(0, 1'b0, 32'h20, 32'h0, 32'h1, 1'b0, 1'b1);
    finish_txn(0);
`endif

    txn(0, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    finish_txn(0);

    // Abort a write one cycle into BUSY; the word must stay cleared.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'hAAAA_5555;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready[0]), 32'd0);
    check("abort_rdata", rdata[0], 32'd0);
    check("abort_error", 32'(err[0]), 32'd0);
    check("abort_init_done", 32'(idone[0]), 32'd0);
    check("abort_rdata_lat3", rdata[1], 32'd0);
    req[0] = 1'b0;
    held[0] = '0; held[1] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_init(n, early);
    check("reinit_edges", 32'(n), 32'd1024);
    txn(0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
    txn(0, 1'b0, 32'hFFC, 32'h0, 32'h0, 1'b0, 1'b1);
    finish_txn(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
